// File: rtl/psum_pkg.sv
// -----------------------------------------------------------------------------
// psum_pkg
//
// Shared definitions for the partial-sum accumulate/writeback block:
//   - state_t    : controller states (IDLE / POP / ADD)
//   - PSUM_BW    : default lane width in bits
//   - PSUM_MAX   : largest signed value of a default-width lane
//   - PSUM_MIN   : smallest signed value of a default-width lane
//   - lane_lo()  : bit offset of lane i inside a packed vector
//
// Optional feature macro: PSUM_SAT_EN (consumed by psum_lane_add).
// -----------------------------------------------------------------------------
package psum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        ADD  = 2'd2
    } state_t;

    localparam int PSUM_BW = 16;

    localparam logic signed [PSUM_BW-1:0] PSUM_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic signed [PSUM_BW-1:0] PSUM_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

    // Lane i of a packed vector occupies [lane_lo(i, w) +: w].
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/psum_lane_add.sv
// -----------------------------------------------------------------------------
// psum_lane_add
//
// One lane of the accumulate datapath: y = a + b (signed), computed one bit
// wider than the lane and then narrowed, followed by an optional ReLU.
//
// Ports:
//   a        in  W   incoming partial sum from the ofifo
//   b        in  W   previous accumulated value (zero on the first pass)
//   relu_en  in  1   clamp negative results to zero
//   y        out W   value to write back
//
// Macro PSUM_SAT_EN:
//   defined   -> overflow saturates to the signed lane range
//   undefined -> two's-complement wrap (low W bits kept)
// -----------------------------------------------------------------------------
module psum_lane_add
    import psum_pkg::*;
#(
    parameter int W = PSUM_BW
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                relu_en,
    output logic signed [W-1:0] y
);

    logic signed [W:0]   wide;
    logic signed [W-1:0] fit;

    // Sign-extend both operands so the carry out of the lane is visible.
    assign wide = {a[W-1], a} + {b[W-1], b};

`ifdef PSUM_SAT_EN
    localparam logic signed [W-1:0] LANE_MAX = (W == PSUM_BW) ? W'(PSUM_MAX)
                                                              : {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] LANE_MIN = (W == PSUM_BW) ? W'(PSUM_MIN)
                                                              : {1'b1, {(W-1){1'b0}}};

    // The two top bits of the wide sum disagree exactly when the result
    // does not fit in W bits; the top bit then gives the overflow direction.
    always_comb begin
        fit = wide[W-1:0];
        if (wide[W] != wide[W-1]) begin
            fit = wide[W] ? LANE_MIN : LANE_MAX;
        end
    end
`else
    logic unused_carry;

    assign unused_carry = wide[W];
    assign fit          = wide[W-1:0];
`endif

    assign y = (relu_en && fit[W-1]) ? '0 : fit;

endmodule

// File: rtl/psum_accum_writeback.sv
// -----------------------------------------------------------------------------
// psum_accum_writeback
//
// Drains the systolic array's output FIFO and read-modify-write accumulates
// each col-lane partial-sum vector into psum SRAM over kij_len passes of
// num_inp vectors. On the last pass an optional ReLU is applied before the
// final write, leaving finished outputs in the SRAM.
//
// Ports:
//   clk         in   1            rising-edge clock
//   reset       in   1            asynchronous, active-low
//   start       in   1            begin a layer (ignored while busy)
//   relu        in   1            sampled with start; ReLU on the last pass
//   o_valid     in   1            ofifo non-empty, ofifo_dout valid (FWFT)
//   ofifo_dout  in   col*psum_bw  head vector, lane i at [i*psum_bw +: psum_bw]
//   o_rd        out  1            pop the ofifo at this edge
//   mem_cen     out  1            SRAM chip enable, active-low
//   mem_wen     out  1            SRAM write enable, active-low
//   mem_addr    out  addr_bw      SRAM address
//   mem_din     out  col*psum_bw  SRAM write data
//   mem_dout    in   col*psum_bw  SRAM read data, one cycle after the read
//   busy        out  1            layer in progress
//   pass_done   out  1            pulse after the last write of each pass
//   layer_done  out  1            pulse after the last write of the layer
//
// Macro PSUM_SAT_EN: saturating lane adds instead of wrap-around.
// -----------------------------------------------------------------------------
module psum_accum_writeback
    import psum_pkg::*;
#(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int num_inp = 64,
    parameter int kij_len = 9,
    parameter int addr_bw = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     relu,
    input  logic                     o_valid,
    input  logic [col*psum_bw-1:0]   ofifo_dout,
    output logic                     o_rd,
    output logic                     mem_cen,
    output logic                     mem_wen,
    output logic [addr_bw-1:0]       mem_addr,
    output logic [col*psum_bw-1:0]   mem_din,
    input  logic [col*psum_bw-1:0]   mem_dout,
    output logic                     busy,
    output logic                     pass_done,
    output logic                     layer_done
);

    localparam int KIJ_BW = (kij_len > 1) ? $clog2(kij_len) : 1;

    localparam logic [addr_bw-1:0] ADDR_LAST = addr_bw'(num_inp - 1);
    localparam logic [KIJ_BW-1:0]  KIJ_LAST  = KIJ_BW'(kij_len - 1);

    state_t                  state_reg;
    logic [addr_bw-1:0]      addr_reg;
    logic [KIJ_BW-1:0]       kij_reg;
    logic                    relu_reg;
    logic [col*psum_bw-1:0]  acc_in_reg;
    logic                    pass_done_reg;
    logic                    layer_done_reg;

    logic                    first_pass;
    logic                    last_pass;
    logic                    last_addr;
    logic                    relu_active;
    logic                    pop_now;
    logic [col*psum_bw-1:0]  sum;

    assign first_pass  = (kij_reg == '0);
    assign last_pass   = (kij_reg == KIJ_LAST);
    assign last_addr   = (addr_reg == ADDR_LAST);
    assign relu_active = relu_reg && last_pass;
    assign pop_now     = (state_reg == POP) && o_valid;

    // ------------------------------------------------------------------
    // Lane datapath: the previous accumulation is ignored on pass 0, so
    // stale SRAM contents from an earlier layer never leak in.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < col; gi++) begin : g_lane
            logic [psum_bw-1:0] prev_lane;

            assign prev_lane = first_pass ? '0
                                          : mem_dout[lane_lo(gi, psum_bw) +: psum_bw];

            psum_lane_add #(
                .W (psum_bw)
            ) u_lane (
                .a       (acc_in_reg[lane_lo(gi, psum_bw) +: psum_bw]),
                .b       (prev_lane),
                .relu_en (relu_active),
                .y       (sum[lane_lo(gi, psum_bw) +: psum_bw])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Controller: state, counters, captured head vector and the
    // end-of-pass / end-of-layer pulses.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            kij_reg        <= '0;
            relu_reg       <= 1'b0;
            acc_in_reg     <= '0;
            pass_done_reg  <= 1'b0;
            layer_done_reg <= 1'b0;
        end else begin
            pass_done_reg  <= 1'b0;
            layer_done_reg <= 1'b0;

            unique case (state_reg)
                IDLE: begin
                    // The layer_done cycle still counts as busy, so a start
                    // landing there is dropped like any other mid-layer start.
                    if (start && !layer_done_reg) begin
                        addr_reg  <= '0;
                        kij_reg   <= '0;
                        relu_reg  <= relu;
                        state_reg <= POP;
                    end
                end

                POP: begin
                    if (o_valid) begin
                        acc_in_reg <= ofifo_dout;
                        state_reg  <= ADD;
                    end
                end

                ADD: begin
                    if (last_addr) begin
                        addr_reg      <= '0;
                        pass_done_reg <= 1'b1;
                        if (last_pass) begin
                            layer_done_reg <= 1'b1;
                            state_reg      <= IDLE;
                        end else begin
                            kij_reg   <= kij_reg + 1'b1;
                            state_reg <= POP;
                        end
                    end else begin
                        addr_reg  <= addr_reg + 1'b1;
                        state_reg <= POP;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pop and SRAM strobes are decoded from the registered state. They must
    // follow o_valid within the same POP cycle (no pop or read while the
    // FIFO is empty), and the write data depends on SRAM read data that only
    // arrives in the ADD cycle, so registering them would cost a cycle per
    // vector. In IDLE (including straight out of reset) every strobe is idle.
    // ------------------------------------------------------------------
    always_comb begin
        o_rd     = pop_now;
        mem_cen  = 1'b1;
        mem_wen  = 1'b1;
        mem_addr = addr_reg;
        mem_din  = '0;

        if (pop_now && !first_pass) begin
            mem_cen = 1'b0;
        end

        if (state_reg == ADD) begin
            mem_cen = 1'b0;
            mem_wen = 1'b0;
            mem_din = sum;
        end
    end

    assign busy       = (state_reg != IDLE) || layer_done_reg;
    assign pass_done  = pass_done_reg;
    assign layer_done = layer_done_reg;

endmodule

// File: tb/tb_psum_accum_writeback.sv
// -----------------------------------------------------------------------------
// tb_psum_accum_writeback
//
// Bench for psum_accum_writeback with num_inp=4, kij_len=3. Provides a
// first-word-fall-through FIFO model and a one-cycle-latency SRAM model.
// Every vector pushed into the FIFO also pushes its expected write
// {addr, data} onto a scoreboard queue; each DUT write pops and compares.
// A table of layer vectors (with hand-derived final SRAM contents) is run in
// a loop, followed by a random layer, a mid-layer reset abort and a restart.
// -----------------------------------------------------------------------------
module tb_psum_accum_writeback;

    localparam int COL  = 8;
    localparam int BW   = 16;
    localparam int NINP = 4;
    localparam int KIJ  = 3;
    localparam int VW   = COL * BW;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            relu;
    logic            o_valid;
    logic [VW-1:0]   ofifo_dout;
    logic            o_rd;
    logic            mem_cen;
    logic            mem_wen;
    logic [1:0]      mem_addr;
    logic [VW-1:0]   mem_din;
    logic [VW-1:0]   mem_dout;
    logic            busy;
    logic            pass_done;
    logic            layer_done;

    psum_accum_writeback #(
        .col     (COL),
        .psum_bw (BW),
        .num_inp (NINP),
        .kij_len (KIJ),
        .addr_bw (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .relu       (relu),
        .o_valid    (o_valid),
        .ofifo_dout (ofifo_dout),
        .o_rd       (o_rd),
        .mem_cen    (mem_cen),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .busy       (busy),
        .pass_done  (pass_done),
        .layer_done (layer_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    addr;
        logic [VW-1:0] data;
    } wr_t;

    typedef struct {
        bit                        relu;
        logic [2:0][7:0][15:0]     pv;      // pv[pass][lane], same for every address
        logic [7:0][15:0]          ex;      // final SRAM lanes
        int                        st_lo;
        int                        st_hi;
        int                        glitch;
        int                        cyc;     // cycles from start to layer_done
    } vec_t;

    vec_t          tbl [4];
    logic [VW-1:0] sram [NINP];
    logic [VW-1:0] fifo_q [$];
    wr_t           exp_q [$];
    logic [VW-1:0] layer_vec [KIJ][NINP];
    logic [VW-1:0] model_acc [NINP];

    int tests = 0;
    int fails = 0;
    int cyc, stall_lo, stall_hi;
    int pass_pulses, reads;
    bit prev_pop;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] lane_model(input logic [15:0] a, input logic [15:0] b,
                                               input bit use_b, input bit relu_on);
        int          s;
        logic [15:0] r;
        s = int'($signed(a)) + (use_b ? int'($signed(b)) : 0);
`ifdef PSUM_SAT_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`endif
        r = s[15:0];
        if (relu_on && r[15]) r = '0;
        return r;
    endfunction

    task automatic drive_inputs();
        bit stall;
        stall      = (cyc >= stall_lo) && (cyc < stall_hi);
        o_valid    = !stall && (fifo_q.size() > 0);
        ofifo_dout = o_valid ? fifo_q[0] : '0;
    endtask

    // Called at a settled point (#1 after negedge); ends at the next one.
    task automatic step();
        bit         pop, rd, wr;
        logic [1:0] a;
        logic [VW-1:0] d;
        wr_t        e;
        pop = o_rd;
        rd  = !mem_cen && mem_wen;
        wr  = !mem_cen && !mem_wen;
        a   = mem_addr;
        d   = mem_din;
        if (pass_done) pass_pulses++;
        if (!o_valid) chk("o_rd_without_valid", o_rd, 0);
        if (!o_valid && !prev_pop) chk("strobes_idle", mem_cen, 1);
        prev_pop = pop;
        if (wr) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data %h required no write", a, d);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", a, e.addr);
                chk("wr_data", d, e.data);
            end
        end
        if (rd) reads++;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (wr) sram[a] = d;
        if (rd) mem_dout = sram[a];
        @(negedge clk);
        cyc++;
        drive_inputs();
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_o_rd",       o_rd,       0);
        chk("rst_mem_cen",    mem_cen,    1);
        chk("rst_mem_wen",    mem_wen,    1);
        chk("rst_mem_addr",   mem_addr,   0);
        chk("rst_mem_din",    mem_din,    0);
        chk("rst_busy",       busy,       0);
        chk("rst_pass_done",  pass_done,  0);
        chk("rst_layer_done", layer_done, 0);
    endtask

    task automatic push_layer(input bit relu_in);
        logic [VW-1:0] v, r;
        wr_t           e;
        for (int p = 0; p < KIJ; p++) begin
            for (int a = 0; a < NINP; a++) begin
                v = layer_vec[p][a];
                fifo_q.push_back(v);
                for (int i = 0; i < COL; i++) begin
                    r[i*BW +: BW] = lane_model(v[i*BW +: BW], model_acc[a][i*BW +: BW],
                                               p != 0, relu_in && (p == KIJ - 1));
                end
                model_acc[a] = r;
                e.addr = 2'(a);
                e.data = r;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_layer(input bit relu_in, input int st_lo, input int st_hi,
                             input int glitch, input int abort_at, input int exp_cyc,
                             input bit use_tab, input logic [7:0][15:0] tab_ex);
        bit done;
        done = 0;
        push_layer(relu_in);
        stall_lo    = st_lo;
        stall_hi    = st_hi;
        pass_pulses = 0;
        reads       = 0;
        prev_pop    = 0;
        cyc         = 0;
        drive_inputs();
        #1;
        relu  = relu_in;
        start = 1'b1;
        chk("busy_before_start", busy, 0);
        while (!done && cyc <= 200) begin
            if (cyc == glitch) begin
                start = 1'b1;
                relu  = !relu_in;
            end
            if (cyc == 1) chk("busy_after_start", busy, 1);
            if (cyc == abort_at) begin
                reset = 1'b0;
                #1;
                check_reset_outputs();
                fifo_q.delete();
                exp_q.delete();
                step();
                step();
                reset = 1'b1;
                #1;
                return;
            end
            if (layer_done) begin
                chk("layer_done_cycle", 32'(cyc), 32'(exp_cyc));
                chk("busy_at_layer_done", busy, 1);
                done = 1;
            end
            step();
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL layer_timeout: got no layer_done after %0d cycles required %0d", cyc, exp_cyc);
        end
        chk("busy_after_layer", busy, 0);
        chk("pass_done_count", 32'(pass_pulses), 32'(KIJ));
        chk("read_count", 32'(reads), 32'(NINP * (KIJ - 1)));
        chk("writes_left", 32'(exp_q.size()), 0);
        chk("fifo_left", 32'(fifo_q.size()), 0);
        for (int a = 0; a < NINP; a++) begin
            chk("sram_vs_model", sram[a], model_acc[a]);
            if (use_tab) chk("sram_vs_table", sram[a], tab_ex);
        end
        exp_q.delete();
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        relu     = 1'b0;
        mem_dout = '0;
        stall_lo = -1;
        stall_hi = -1;
        cyc      = 0;
        prev_pop = 0;
        for (int a = 0; a < NINP; a++) begin
            sram[a]      = '0;
            model_acc[a] = '0;
        end
        drive_inputs();
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;

        // Vector table: inputs per pass and hand-derived final SRAM lanes.
        for (int t = 0; t < 4; t++) begin
            tbl[t].relu   = 0;
            tbl[t].st_lo  = -1;
            tbl[t].st_hi  = -1;
            tbl[t].glitch = -1;
            tbl[t].cyc    = 2 * NINP * KIJ + 1;
        end
        for (int i = 0; i < COL; i++) begin
            for (int p = 0; p < KIJ; p++) begin
                tbl[0].pv[p][i] = 16'd5;
                tbl[1].pv[p][i] = 16'(i - 3);
                tbl[2].pv[p][i] = 16'(i - 3);
                tbl[3].pv[p][i] = 16'hFFFF;
            end
            tbl[0].ex[i] = 16'd15;
            tbl[1].ex[i] = 16'(3 * (i - 3));
            tbl[2].ex[i] = (i < 3) ? 16'd0 : 16'(3 * (i - 3));
            tbl[3].ex[i] = 16'hFFFD;
        end
        tbl[2].relu     = 1;
        tbl[1].st_lo    = 7;      // FIFO empty for 5 POP cycles
        tbl[1].st_hi    = 12;
        tbl[1].glitch   = 15;     // start while busy, relu flipped
        tbl[1].cyc      = 2 * NINP * KIJ + 1 + 5;
        tbl[3].pv[0][0] = 16'h7FFF;
        tbl[3].pv[1][0] = 16'h0001;
        tbl[3].pv[2][0] = 16'h0000;
`ifdef PSUM_SAT_EN
        tbl[3].ex[0]    = 16'h7FFF;
`else
        tbl[3].ex[0]    = 16'h8000;
`endif

        for (int t = 0; t < 4; t++) begin
            for (int p = 0; p < KIJ; p++)
                for (int a = 0; a < NINP; a++)
                    layer_vec[p][a] = tbl[t].pv[p];
            run_layer(tbl[t].relu, tbl[t].st_lo, tbl[t].st_hi, tbl[t].glitch, -1,
                      tbl[t].cyc, 1, tbl[t].ex);
        end

        // Random per-address data with ReLU: checked against the model only.
        for (int p = 0; p < KIJ; p++)
            for (int a = 0; a < NINP; a++)
                for (int i = 0; i < COL; i++)
                    layer_vec[p][a][i*BW +: BW] = 16'($urandom);
        run_layer(1, -1, -1, -1, -1, 2 * NINP * KIJ + 1, 0, '0);

        // Reset during the first ADD of pass 1, then a clean restart.
        run_layer(0, -1, -1, -1, 2 * NINP + 2, 2 * NINP * KIJ + 1, 0, '0);
        for (int p = 0; p < KIJ; p++)
            for (int a = 0; a < NINP; a++)
                layer_vec[p][a] = tbl[0].pv[p];
        run_layer(0, -1, -1, -1, -1, tbl[0].cyc, 1, tbl[0].ex);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
